fc_class_reader: RTL

- Consumes the ten signed 16-bit post-ReLU outputs of the fully connected layer.
- Snapshots them on a start pulse and scans them one per clock to find the winning class.
- Presents the class index and score on a valid/ready output handshake.
- Sits between the FC/ReLU array and the result interface; it is the read-side counterpart of the FC layer.

---
 rtl/fc_pkg.sv | 14 +
 rtl/fc_class_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully connected layer and its class read-out stage.
package fc_pkg;
    localparam int N_OUT  = 10;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic signed [DATA_W-1:0] neuron_t;
endpackage

// File: rtl/fc_class_reader.sv
// Snapshots the FC layer outputs on start, scans them one per clock for the
// largest signed value and offers index/score on a valid/ready handshake.
module fc_class_reader
    import fc_pkg::*;
#(
    parameter int N_OUT  = fc_pkg::N_OUT,
    parameter int DATA_W = fc_pkg::DATA_W,
    parameter int IDX_W  = fc_pkg::IDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_OUT*DATA_W-1:0]  in_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         class_idx,
    output logic signed [DATA_W-1:0] class_score,
    output logic                     no_detect
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_e state_q, state_d;

    logic signed [DATA_W-1:0] snap_q [N_OUT];
    logic signed [DATA_W-1:0] snap_d [N_OUT];
    logic signed [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d;

    logic                     busy_q, busy_d;
    logic                     out_valid_q, out_valid_d;
    logic [IDX_W-1:0]         class_idx_q, class_idx_d;
    logic signed [DATA_W-1:0] class_score_q, class_score_d;
    logic                     no_detect_q, no_detect_d;

    logic signed [DATA_W-1:0] cand_s;
    logic signed [DATA_W-1:0] upd_max_s;
    logic [IDX_W-1:0]         upd_idx_s;
    logic                     last_s;

    // Strict greater-than keeps the earliest index on ties.
    assign cand_s    = snap_q[cnt_q];
    assign upd_max_s = (cand_s > max_q) ? cand_s : max_q;
    assign upd_idx_s = (cand_s > max_q) ? cnt_q : idx_q;
    assign last_s    = (cnt_q == LAST_IDX);

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            max_q         <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            no_detect_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            max_q         <= max_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            no_detect_q   <= no_detect_d;
        end
    end

    // Snapshot storage; contents are only meaningful after a capture.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = SCAN;
                else       state_d = IDLE;
            end
            SCAN: begin
                if (last_s) state_d = DONE;
                else        state_d = SCAN;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
                else           state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture and running-maximum datapath.
    always_comb begin
        snap_d = snap_q;
        max_d  = max_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < N_OUT; i++) begin
                        snap_d[i] = in_data[i*DATA_W +: DATA_W];
                    end
                    max_d = in_data[DATA_W-1:0];
                    idx_d = '0;
                    cnt_d = ONE_IDX;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            SCAN: begin
                max_d = upd_max_s;
                idx_d = upd_idx_s;
                cnt_d = cnt_q + ONE_IDX;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Output register next values; result fields hold until the next scan.
    always_comb begin
        busy_d        = busy_q;
        out_valid_d   = out_valid_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        no_detect_d   = no_detect_q;
        case (state_q)
            IDLE: begin
                busy_d      = start;
                out_valid_d = 1'b0;
            end
            SCAN: begin
                busy_d = 1'b1;
                if (last_s) begin
                    out_valid_d   = 1'b1;
                    class_idx_d   = upd_idx_s;
                    class_score_d = upd_max_s;
                    no_detect_d   = (upd_max_s[DATA_W-1] == 1'b1) ||
                                    (upd_max_s == {DATA_W{1'b0}});
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    busy_d      = 1'b0;
                    out_valid_d = 1'b0;
                end else begin
                    busy_d      = 1'b1;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;
    assign no_detect   = no_detect_q;

endmodule
